// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. One operation is in flight at a time.
// The ALU inputs are driven from registers, and the result returns on the owner's response channel.
module alu_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_z,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_z,
    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_rd,
    input  logic             alu_z,
    output logic             busy
);

    localparam int unsigned CTRL_W = 3;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  rs1_q, rs1_d;
    logic [WIDTH-1:0]  rs2_q, rs2_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  data0_q, data0_d;
    logic [WIDTH-1:0]  data1_q, data1_d;
    logic              z0_q, z0_d;
    logic              z1_q, z1_d;

    logic              winner_c;
    logic              accept_c;
    logic              legal_c;
    logic              rsp_hs_c;
    logic [WIDTH-1:0]  sel_a_c;
    logic [WIDTH-1:0]  sel_b_c;
    logic [CTRL_W-1:0] sel_ctrl_c;

    // A lone requester wins; on a tie the one not served last wins.
    always_comb begin
        winner_c = 1'b0;
        if (req0_valid && req1_valid) begin
            winner_c = ~last_grant_q;
        end else if (req1_valid) begin
            winner_c = 1'b1;
        end
    end

    assign accept_c   = (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = rst_n && accept_c && !winner_c;
    assign req1_ready = rst_n && accept_c && winner_c;

    assign sel_a_c    = winner_c ? req1_a    : req0_a;
    assign sel_b_c    = winner_c ? req1_b    : req0_b;
    assign sel_ctrl_c = winner_c ? req1_ctrl : req0_ctrl;
    assign rsp_hs_c   = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        case (sel_ctrl_c)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: legal_c = 1'b1;
            default:                                legal_c = 1'b0;
        endcase
    end

    // Next-state logic. Illegal ops skip the ALU and answer with data 0 and z set.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        ctrl_d       = ctrl_q;
        data0_d      = data0_q;
        data1_d      = data1_q;
        z0_d         = z0_q;
        z1_d         = z1_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    owner_d = winner_c;
                    if (legal_c) begin
                        rs1_d   = sel_a_c;
                        rs2_d   = sel_b_c;
                        ctrl_d  = sel_ctrl_c;
                        cnt_d   = CNT_W'(ALU_LAT);
                        state_d = EXEC;
                    end else begin
                        if (winner_c) begin
                            data1_d = '0;
                            z1_d    = 1'b1;
                        end else begin
                            data0_d = '0;
                            z0_d    = 1'b1;
                        end
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        data1_d = alu_rd;
                        z1_d    = alu_z;
                    end else begin
                        data0_d = alu_rd;
                        z0_d    = alu_z;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_hs_c) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            ctrl_q       <= '0;
            data0_q      <= '0;
            data1_q      <= '0;
            z0_q         <= 1'b0;
            z1_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            ctrl_q       <= ctrl_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            z0_q         <= z0_d;
            z1_q         <= z1_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp0_data  = data0_q;
    assign rsp1_data  = data1_q;
    assign rsp0_z     = z0_q;
    assign rsp1_z     = z1_q;
    assign alu_rs1    = rs1_q;
    assign alu_rs2    = rs2_q;
    assign alu_ctrl   = ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. Three instances (ALU_LAT 1, 0, 3) each drive a latency-accurate ALU model.
// Directed tables, corner sequences and random traffic are all checked against bench-side expectations.
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n     [NI];
    logic         req_valid [NI][2];
    logic         req_ready [NI][2];
    logic [W-1:0] req_a     [NI][2];
    logic [W-1:0] req_b     [NI][2];
    logic [2:0]   req_ctrl  [NI][2];
    logic         rsp_valid [NI][2];
    logic         rsp_ready [NI][2];
    logic [W-1:0] rsp_data  [NI][2];
    logic         rsp_z     [NI][2];
    logic [W-1:0] alu_rs1   [NI];
    logic [W-1:0] alu_rs2   [NI];
    logic [2:0]   alu_ctrl  [NI];
    logic         busy      [NI];

    logic [W-1:0] exp_rs1 [NI];
    logic [W-1:0] exp_rs2 [NI];
    logic [2:0]   exp_ctl [NI];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         z;
        int           r;
    } vec_t;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    function automatic bit is_legal(input logic [2:0] c);
        return (c == 3'b000) || (c == 3'b001) || (c == 3'b010) || (c == 3'b011) || (c == 3'b101);
    endfunction

    function automatic logic [W-1:0] alu_f(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [W-1:0] pipe [3];
        logic [W-1:0] rd_c;
        logic         z_c;

        // ALU model: result appears L cycles after its inputs settle.
        always_ff @(posedge clk) begin
            pipe[0] <= alu_f(alu_ctrl[g], alu_rs1[g], alu_rs2[g]);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        if (L == 0) begin : g_comb
            assign rd_c = alu_f(alu_ctrl[g], alu_rs1[g], alu_rs2[g]);
        end else begin : g_pipe
            assign rd_c = pipe[L-1];
        end
        assign z_c = (rd_c == '0);

        alu_arbiter #(.WIDTH(W), .ALU_LAT(L)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .req0_valid (req_valid[g][0]),
            .req0_ready (req_ready[g][0]),
            .req0_a     (req_a[g][0]),
            .req0_b     (req_b[g][0]),
            .req0_ctrl  (req_ctrl[g][0]),
            .rsp0_valid (rsp_valid[g][0]),
            .rsp0_ready (rsp_ready[g][0]),
            .rsp0_data  (rsp_data[g][0]),
            .rsp0_z     (rsp_z[g][0]),
            .req1_valid (req_valid[g][1]),
            .req1_ready (req_ready[g][1]),
            .req1_a     (req_a[g][1]),
            .req1_b     (req_b[g][1]),
            .req1_ctrl  (req_ctrl[g][1]),
            .rsp1_valid (rsp_valid[g][1]),
            .rsp1_ready (rsp_ready[g][1]),
            .rsp1_data  (rsp_data[g][1]),
            .rsp1_z     (rsp_z[g][1]),
            .alu_rs1    (alu_rs1[g]),
            .alu_rs2    (alu_rs2[g]),
            .alu_ctrl   (alu_ctrl[g]),
            .alu_rd     (rd_c),
            .alu_z      (z_c),
            .busy       (busy[g])
        );
    end

    task automatic check(input string name, input int i, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t: got 0x%0h expected 0x%0h", name, i, $time, act, exp);
        end
    endtask

    task automatic check1(input string name, input int i, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t: got %0b expected %0b", name, i, $time, act, exp);
        end
    endtask

    task automatic clear_inputs(input int i);
        for (int r = 0; r < 2; r++) begin
            req_valid[i][r] = 1'b0;
            req_a[i][r]     = '0;
            req_b[i][r]     = '0;
            req_ctrl[i][r]  = '0;
            rsp_ready[i][r] = 1'b0;
        end
    endtask

    task automatic reset_inst(input int i);
        clear_inputs(i);
        @(posedge clk); #1 rst_n[i] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n[i] = 1'b1;
        exp_rs1[i] = '0;
        exp_rs2[i] = '0;
        exp_ctl[i] = '0;
    endtask

    task automatic drive_req(input int i, input int r, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i][r] = 1'b1;
        req_ctrl[i][r]  = c;
        req_a[i][r]     = a;
        req_b[i][r]     = b;
    endtask

    // Waits (bounded) for a response valid; the final compare records a timeout.
    task automatic wait_rsp(input int i, input int r, input int max_c);
        for (int k = 0; k < max_c; k++) begin
            @(negedge clk);
            if (rsp_valid[i][r]) break;
        end
        check1("rsp_arrives", i, rsp_valid[i][r], 1'b1);
    endtask

    // Single op with exact latency, ALU-drive hold and response stability.
    task automatic run_op(input int i, input vec_t v);
        int  o;
        int  elat;
        bit  legal;
        o     = 1 - v.r;
        legal = is_legal(v.ctrl);
        elat  = legal ? 2 + lat_of(i) : 1;
        @(posedge clk); #1;
        drive_req(i, v.r, v.ctrl, v.a, v.b);
        rsp_ready[i][v.r] = 1'b0;
        @(negedge clk);
        check1("op_req_ready", i, req_ready[i][v.r], 1'b1);
        check1("op_busy_pre", i, busy[i], 1'b0);
        @(posedge clk); #1;
        req_valid[i][v.r] = 1'b0;
        req_a[i][v.r]     = $urandom;
        req_b[i][v.r]     = $urandom;
        if (legal) begin
            exp_rs1[i] = v.a;
            exp_rs2[i] = v.b;
            exp_ctl[i] = v.ctrl;
        end
        for (int k = 1; k <= elat; k++) begin
            @(negedge clk);
            check1("op_rsp_valid", i, rsp_valid[i][v.r], k == elat);
            check1("op_other_valid", i, rsp_valid[i][o], 1'b0);
            check1("op_busy", i, busy[i], 1'b1);
            check("op_alu_rs1", i, alu_rs1[i], exp_rs1[i]);
            check("op_alu_rs2", i, alu_rs2[i], exp_rs2[i]);
            check("op_alu_ctrl", i, W'(alu_ctrl[i]), W'(exp_ctl[i]));
        end
        check("op_data", i, rsp_data[i][v.r], v.d);
        check1("op_z", i, rsp_z[i][v.r], v.z);
        @(posedge clk); #1 rsp_ready[i][v.r] = 1'b1;
        @(negedge clk);
        check1("op_valid_held", i, rsp_valid[i][v.r], 1'b1);
        check("op_data_held", i, rsp_data[i][v.r], v.d);
        @(posedge clk); #1 rsp_ready[i][v.r] = 1'b0;
        @(negedge clk);
        check1("op_valid_drop", i, rsp_valid[i][v.r], 1'b0);
        check1("op_busy_drop", i, busy[i], 1'b0);
    endtask

    // Random traffic against a transaction-level model: grant order, response time, result.
    task automatic random_run(input int i, input int ncyc);
        bit busy_m, own, lg, acc0, acc1, v0, v1, w;
        int due;
        logic [W-1:0] ed, a, b;
        logic ez;
        logic [2:0] c;
        reset_inst(i);
        lg = 1'b1; busy_m = 1'b0; own = 1'b0; due = 0; acc0 = 1'b0; acc1 = 1'b0; ed = '0; ez = 1'b0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(posedge clk); #1;
            if (acc0) req_valid[i][0] = 1'b0;
            if (acc1) req_valid[i][1] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[i][r] && cyc < ncyc - 20 && $urandom_range(0, 2) == 0) begin
                    a = $urandom;
                    b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
                    drive_req(i, r, 3'($urandom_range(0, 7)), a, b);
                end
                rsp_ready[i][r] = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            v0 = req_valid[i][0];
            v1 = req_valid[i][1];
            w  = (v0 && v1) ? !lg : v1;
            check1("rnd_ready0", i, req_ready[i][0], !busy_m && v0 && !w);
            check1("rnd_ready1", i, req_ready[i][1], !busy_m && v1 && w);
            check1("rnd_busy", i, busy[i], busy_m);
            check1("rnd_rsp0_valid", i, rsp_valid[i][0], busy_m && cyc >= due && !own);
            check1("rnd_rsp1_valid", i, rsp_valid[i][1], busy_m && cyc >= due && own);
            acc0 = 1'b0;
            acc1 = 1'b0;
            if (busy_m && cyc >= due) begin
                check("rnd_data", i, rsp_data[i][own], ed);
                check1("rnd_z", i, rsp_z[i][own], ez);
                if (rsp_ready[i][own]) begin
                    busy_m = 1'b0;
                    lg     = own;
                end
            end else if (!busy_m && (v0 || v1)) begin
                busy_m = 1'b1;
                own    = w;
                if (w) acc1 = 1'b1; else acc0 = 1'b1;
                c = req_ctrl[i][w];
                a = req_a[i][w];
                b = req_b[i][w];
                if (is_legal(c)) begin
                    ed  = alu_f(c, a, b);
                    ez  = (ed == '0);
                    due = cyc + 2 + lat_of(i);
                end else begin
                    ed  = '0;
                    ez  = 1'b1;
                    due = cyc + 1;
                end
            end
        end
        clear_inputs(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        vec_t tbl [10];
        tbl[0] = '{3'b000, 32'd20, 32'd30, 32'd50, 1'b0, 0};
        tbl[1] = '{3'b001, 32'd20, 32'd30, 32'hFFFF_FFF6, 1'b0, 1};
        tbl[2] = '{3'b001, 32'd30, 32'd30, 32'd0, 1'b1, 0};
        tbl[3] = '{3'b101, 32'd20, 32'd30, 32'd1, 1'b0, 1};
        tbl[4] = '{3'b011, 32'd20, 32'd30, 32'd30, 1'b0, 0};
        tbl[5] = '{3'b010, 32'd20, 32'd30, 32'd20, 1'b0, 1};
        tbl[6] = '{3'b111, 32'd5, 32'd7, 32'd0, 1'b1, 0};
        tbl[7] = '{3'b101, 32'd30, 32'd20, 32'd0, 1'b1, 1};
        tbl[8] = '{3'b100, 32'd1, 32'd2, 32'd0, 1'b1, 1};
        tbl[9] = '{3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 0};

        // Reset state, with valids high to confirm ready is held low.
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0;
            clear_inputs(i);
            req_valid[i][0] = 1'b1;
            req_valid[i][1] = 1'b1;
            exp_rs1[i] = '0;
            exp_rs2[i] = '0;
            exp_ctl[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            for (int r = 0; r < 2; r++) begin
                check1("rst_req_ready", i, req_ready[i][r], 1'b0);
                check1("rst_rsp_valid", i, rsp_valid[i][r], 1'b0);
                check("rst_rsp_data", i, rsp_data[i][r], '0);
                check1("rst_rsp_z", i, rsp_z[i][r], 1'b0);
            end
            check("rst_alu_rs1", i, alu_rs1[i], '0);
            check("rst_alu_rs2", i, alu_rs2[i], '0);
            check("rst_alu_ctrl", i, W'(alu_ctrl[i]), '0);
            check1("rst_busy", i, busy[i], 1'b0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b1;
            clear_inputs(i);
        end

        // Tie-break after reset, then round-robin alternation.
        @(posedge clk); #1;
        drive_req(0, 0, 3'b001, 32'd20, 32'd30);
        drive_req(0, 1, 3'b010, 32'd20, 32'd30);
        rsp_ready[0][0] = 1'b1;
        rsp_ready[0][1] = 1'b1;
        @(negedge clk);
        check1("tie_ready0", 0, req_ready[0][0], 1'b1);
        check1("tie_ready1", 0, req_ready[0][1], 1'b0);
        @(posedge clk); #1 req_valid[0][0] = 1'b0;
        wait_rsp(0, 0, 10);
        check("tie_data0", 0, rsp_data[0][0], 32'hFFFF_FFF6);
        check1("tie_z0", 0, rsp_z[0][0], 1'b0);
        @(posedge clk); #1;
        drive_req(0, 0, 3'b011, 32'd20, 32'd30);
        @(negedge clk);
        check1("rr_ready1", 0, req_ready[0][1], 1'b1);
        check1("rr_ready0", 0, req_ready[0][0], 1'b0);
        @(posedge clk); #1 req_valid[0][1] = 1'b0;
        wait_rsp(0, 1, 10);
        check("rr_data1", 0, rsp_data[0][1], 32'd20);
        check1("rr_other_valid", 0, rsp_valid[0][0], 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check1("rr_ready0_next", 0, req_ready[0][0], 1'b1);
        @(posedge clk); #1 req_valid[0][0] = 1'b0;
        wait_rsp(0, 0, 10);
        check("rr_data0", 0, rsp_data[0][0], 32'd30);
        @(posedge clk); #1 clear_inputs(0);
        exp_rs1[0] = 32'd20;
        exp_rs2[0] = 32'd30;
        exp_ctl[0] = 3'b011;

        for (int i = 0; i < NI; i++) begin
            for (int v = 0; v < 10; v++) run_op(i, tbl[v]);
        end

        // Backpressure on requester 1 while requester 0 waits.
        @(posedge clk); #1;
        drive_req(0, 1, 3'b000, 32'd100, 32'd23);
        rsp_ready[0][1] = 1'b0;
        @(negedge clk);
        check1("bp_ready1", 0, req_ready[0][1], 1'b1);
        @(posedge clk); #1;
        req_valid[0][1] = 1'b0;
        drive_req(0, 0, 3'b000, 32'd7, 32'd8);
        wait_rsp(0, 1, 10);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check1("bp_valid", 0, rsp_valid[0][1], 1'b1);
            check("bp_data", 0, rsp_data[0][1], 32'd123);
            check1("bp_z", 0, rsp_z[0][1], 1'b0);
            check1("bp_req0_ready", 0, req_ready[0][0], 1'b0);
            check1("bp_busy", 0, busy[0], 1'b1);
        end
        @(posedge clk); #1 rsp_ready[0][1] = 1'b1;
        @(negedge clk);
        check1("bp_hs_valid", 0, rsp_valid[0][1], 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check1("bp_req0_next", 0, req_ready[0][0], 1'b1);
        check1("bp_valid_drop", 0, rsp_valid[0][1], 1'b0);
        check1("bp_busy_drop", 0, busy[0], 1'b0);
        @(posedge clk); #1;
        req_valid[0][0] = 1'b0;
        rsp_ready[0][0] = 1'b1;
        wait_rsp(0, 0, 10);
        check("bp_data0", 0, rsp_data[0][0], 32'd15);
        @(posedge clk); #1 clear_inputs(0);

        // Asynchronous reset in the middle of EXEC on the ALU_LAT=3 instance.
        @(posedge clk); #1;
        drive_req(2, 0, 3'b000, 32'd1, 32'd2);
        rsp_ready[2][0] = 1'b1;
        @(negedge clk);
        check1("mr_ready0", 2, req_ready[2][0], 1'b1);
        @(posedge clk); #1;
        req_valid[2][0] = 1'b0;
        drive_req(2, 1, 3'b001, 32'd9, 32'd4);
        @(negedge clk);
        check1("mr_busy_exec", 2, busy[2], 1'b1);
        @(posedge clk); #3 rst_n[2] = 1'b0;
        #1;
        check1("mr_busy_async", 2, busy[2], 1'b0);
        check1("mr_ready1_async", 2, req_ready[2][1], 1'b0);
        check1("mr_rsp0_async", 2, rsp_valid[2][0], 1'b0);
        check1("mr_rsp1_async", 2, rsp_valid[2][1], 1'b0);
        check("mr_alu_rs1", 2, alu_rs1[2], '0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        req_valid[2][1] = 1'b0;
        exp_rs1[2] = '0;
        exp_rs2[2] = '0;
        exp_ctl[2] = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check1("mr_no_rsp0", 2, rsp_valid[2][0], 1'b0);
            check1("mr_no_rsp1", 2, rsp_valid[2][1], 1'b0);
            check1("mr_idle", 2, busy[2], 1'b0);
        end
        @(posedge clk); #1;
        drive_req(2, 0, 3'b000, 32'd3, 32'd4);
        drive_req(2, 1, 3'b001, 32'd9, 32'd4);
        rsp_ready[2][0] = 1'b1;
        rsp_ready[2][1] = 1'b1;
        @(negedge clk);
        check1("mr_tie_ready0", 2, req_ready[2][0], 1'b1);
        check1("mr_tie_ready1", 2, req_ready[2][1], 1'b0);
        @(posedge clk); #1 req_valid[2][0] = 1'b0;
        wait_rsp(2, 0, 12);
        check("mr_data0", 2, rsp_data[2][0], 32'd7);
        @(posedge clk); #1;
        @(negedge clk);
        check1("mr_ready1_next", 2, req_ready[2][1], 1'b1);
        @(posedge clk); #1 req_valid[2][1] = 1'b0;
        wait_rsp(2, 1, 12);
        check("mr_data1", 2, rsp_data[2][1], 32'd5);
        @(posedge clk); #1 clear_inputs(2);

        for (int i = 0; i < NI; i++) random_run(i, 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single `alu` instance between two requesters, such as the decode/execute path and a multi-cycle helper unit. Each requester has an independent valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin and drives the ALU operand and control inputs from registers. It waits a configurable ALU latency, captures `rd`/`z`, and returns the result to the winning requester. Only one operation is outstanding at a time.

Parameters:
- WIDTH, 32, operand/result width; matches the ALU `rs1`/`rs2`/`rd`.
- ALU_LAT, 1, cycles from stable ALU inputs until `rd`/`z` are valid; legal range 0..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  arbiter accepts requester 0's op this cycle.
- req0_a  in  WIDTH  operand A (to rs1).
- req0_b  in  WIDTH  operand B (to rs2).
- req0_ctrl  in  3  op code: 000 add, 001 sub, 010 and, 011 or, 101 slt; others illegal.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp0_data  out  WIDTH  result.
- rsp0_z  out  1  zero flag.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  same as requester 0.
- rsp1_valid, rsp1_ready, rsp1_data, rsp1_z  same as requester 0.
- alu_rs1  out  WIDTH  to ALU rs1.
- alu_rs2  out  WIDTH  to ALU rs2.
- alu_ctrl  out  3  to ALU ctrl.
- alu_rd  in  WIDTH  from ALU rd.
- alu_z  in  1  from ALU z.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - All req*_ready, rsp*_valid, rsp*_data, rsp*_z, alu_rs1, alu_rs2, alu_ctrl and busy are 0.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Winner is the only valid requester; if both are valid, the requester != last_grant wins.
  - reqN_ready = (state==IDLE) && winner==N. This is combinational from the valids; requesters must not make valid depend on ready.
  - On valid&&ready: latch a, b, ctrl and owner.
  - Legal ctrl: load cnt=ALU_LAT and go to EXEC.
  - Illegal ctrl (100, 110, 111): load result data=0, z=1 and go directly to RESP. alu_* are not updated.
- EXEC:
  - alu_rs1, alu_rs2, alu_ctrl are registered and take the latched values at the accept edge.
  - They stay constant through EXEC and RESP, and hold afterwards until the next legal accept; there is no toggling in IDLE.
  - Each cycle: if cnt==0, capture alu_rd/alu_z into the result registers and go to RESP; otherwise decrement cnt.
  - EXEC lasts ALU_LAT+1 cycles.
- RESP:
  - rspN_valid=1 for the owner only; the other rsp valid stays 0.
  - rsp data/z are stable while valid && !ready.
  - On rspN_valid && rspN_ready: last_grant=owner, then go to IDLE. rsp valid drops the next cycle.
  - No request is accepted in EXEC or RESP; all req ready are 0.
- Latency:
  - Accept edge at end of cycle T gives rsp_valid high from cycle T+2+ALU_LAT (legal ops).
  - Illegal ops: rsp_valid high from T+1.
  - Minimum turnaround (rsp ready held high): a new accept is possible in the cycle after the response handshake.
- rsp*_data and rsp*_z of the non-owner keep their last value and are don't-care while the corresponding rsp valid is 0.
- Width rules:
  - Data is passed through unmodified; no sign extension.
  - slt results come from the ALU as-is (0 or 1).
- Reset mid-operation: the in-flight transaction is dropped and no response is issued after rst_n releases. last_grant returns to 1.
- A requester that deasserts valid before handshake is simply not granted; there is no stall or error.

Test Plan:
- Add, single requester: only req0 valid, add a=20, b=30, ALU_LAT=1.
  - Required: req0_ready=1 in the same cycle; rsp0_valid at T+3 with data=50, z=0.
  - rsp1_valid stays 0; busy is high from T+1 until the handshake.
- Tie-break after reset: req0 sub 20,30 and req1 and 20,30 both valid from reset.
  - Required: req0 is served first with data=0xFFFFFFF6, z=0; then req1 with data=20.
  - A further simultaneous pair is won by req1 (round-robin).
- Backpressure: hold rsp1_ready=0 for 5 cycles while rsp1_valid=1, with req0_valid=1 throughout.
  - Required: rsp1_data/z stay stable, req0_ready=0, busy=1.
  - After ready rises, req0 is accepted in the next cycle.
- Flags:
  - sub 30,30: data=0, z=1.
  - slt 20,30: data=1, z=0.
  - or 20,30: data=30.
  - Repeat with ALU_LAT=0 (rsp at T+2) and ALU_LAT=3 (rsp at T+5); alu_rs1/rs2/ctrl must be constant through EXEC.
- Illegal op: req0_ctrl=3'b111, a=5, b=7.
  - Required: rsp0_valid at T+1 with data=0, z=1.
  - alu_rs1/alu_rs2/alu_ctrl keep their previous values.
- Reset mid-op: pull rst_n low for 2 cycles in the middle of EXEC (ALU_LAT=3).
  - Required: all valid/ready/busy drop to 0 immediately (asynchronously) and no rsp after release.
  - A simultaneous req0/req1 pair afterwards grants req0 first.
